// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 tables, rotation amounts and the
// helpers that apply them to a 64-bit key or a 56-bit C||D register.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 56;
  localparam int SUBKEY_W = 48;
  localparam int HALF_W   = 28;

  typedef enum logic {IDLE, RUN} state_e;

  // Table entries are DES bit numbers (1 = MSB of the source word).
  localparam int PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] r;
    for (int i = 0; i < CD_W; i++) r[CD_W-1-i] = key[KEY_W-PC1[i]];
    return r;
  endfunction

  // MSB is DES position 1, so a DES left rotation moves the MSB to the LSB.
  function automatic logic [HALF_W-1:0] rotl_half(input logic [HALF_W-1:0] h, input int amt);
    return (amt == 2) ? {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]} : {h[HALF_W-2:0], h[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr_half(input logic [HALF_W-1:0] h, input int amt);
    return (amt == 2) ? {h[1:0], h[HALF_W-1:2]} : {h[0], h[HALF_W-1:1]};
  endfunction

  function automatic logic [CD_W-1:0] rotl_cd(input logic [CD_W-1:0] cd, input int amt);
    return {rotl_half(cd[CD_W-1:HALF_W], amt), rotl_half(cd[HALF_W-1:0], amt)};
  endfunction

  function automatic logic [CD_W-1:0] rotr_cd(input logic [CD_W-1:0] cd, input int amt);
    return {rotr_half(cd[CD_W-1:HALF_W], amt), rotr_half(cd[HALF_W-1:0], amt)};
  endfunction

endpackage

// File: rtl/des_key_sched_rev_if.sv
// Key-in / subkey-out handshake bundle between the key register, the schedule
// generator (slave) and the round engine.
interface des_key_sched_rev_if;

  logic [des_pkg::KEY_W-1:0]    key;
  logic                         decrypt;
  logic                         start;
  logic                         key_ready;
  logic [des_pkg::SUBKEY_W-1:0] subkey;
  logic [3:0]                   subkey_idx;
  logic                         subkey_valid;
  logic                         subkey_ready;
  logic                         done;

  modport slave (
    input  key, decrypt, start, subkey_ready,
    output key_ready, subkey, subkey_idx, subkey_valid, done
  );

  modport master (
    output key, decrypt, start, subkey_ready,
    input  key_ready, subkey, subkey_idx, subkey_valid, done
  );

endinterface

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: selects 48 of the 56 C||D bits to form a round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd_i,
  output logic [SUBKEY_W-1:0] subkey_o
);

  always_comb begin
    for (int i = 0; i < SUBKEY_W; i++) subkey_o[SUBKEY_W-1-i] = cd_i[CD_W-PC2[i]];
  end

endmodule

// File: rtl/des_key_sched_rev.sv
// Sequential DES key schedule: emits K1..K16 (encrypt) or K16..K1 (decrypt)
// one subkey per handshake, rotating C/D in place so no subkey storage is needed.
module des_key_sched_rev
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  des_key_sched_rev_if.slave   bus
);

  localparam logic [3:0] LAST_COUNT = 4'(NUM_ROUNDS - 1);

  state_e                state_q, state_d;
  logic [CD_W-1:0]       cd_q, cd_d;
  logic [3:0]            count_q, count_d;
  logic                  mode_q, mode_d;
  logic [SUBKEY_W-1:0]   subkey_q, subkey_d;
  logic [3:0]            idx_q, idx_d;
  logic                  valid_q, valid_d;
  logic                  key_ready_q, key_ready_d;
  logic                  done_q, done_d;
  logic                  load;
  logic [SUBKEY_W-1:0]   pc2_out;
  logic [CD_W-1:0]       cd0;
  logic [3:0]            enc_sel, dec_sel;

  assign cd0     = pc1(bus.key);
  // Encrypt step n uses s[count+2]; decrypt step j uses s[16-count] (0-based below).
  assign enc_sel = count_q + 4'd1;
  assign dec_sel = 4'd15 - count_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    cd_d        = cd_q;
    count_d     = count_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    key_ready_d = key_ready_q;
    done_d      = 1'b0;
    load        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d      = bus.decrypt;
          count_d     = '0;
          cd_d        = bus.decrypt ? cd0 : rotl_cd(cd0, 1);
          idx_d       = bus.decrypt ? 4'd15 : 4'd0;
          valid_d     = 1'b1;
          key_ready_d = 1'b0;
          state_d     = RUN;
          load        = 1'b1;
        end
      end
      RUN: begin
        if (bus.subkey_ready) begin
          if (count_q != LAST_COUNT) begin
            count_d = count_q + 4'd1;
            load    = 1'b1;
            if (mode_q) begin
              cd_d  = rotr_cd(cd_q, SHIFTS[dec_sel]);
              idx_d = 4'd14 - count_q;
            end else begin
              cd_d  = rotl_cd(cd_q, SHIFTS[enc_sel]);
              idx_d = count_q + 4'd1;
            end
          end else begin
            valid_d     = 1'b0;
            done_d      = 1'b1;
            key_ready_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The subkey is registered from the next C/D, so subkey_ready never reaches it combinationally.
  des_pc2 u_pc2 (
    .cd_i     (cd_d),
    .subkey_o (pc2_out)
  );

  always_comb subkey_d = load ? pc2_out : subkey_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= IDLE;
      cd_q        <= '0;
      count_q     <= '0;
      mode_q      <= 1'b0;
      subkey_q    <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      key_ready_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cd_q        <= cd_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      subkey_q    <= subkey_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      key_ready_q <= key_ready_d;
      done_q      <= done_d;
    end
  end

  assign bus.key_ready    = key_ready_q;
  assign bus.subkey       = subkey_q;
  assign bus.subkey_idx   = idx_q;
  assign bus.subkey_valid = valid_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_des_key_sched_rev.sv
// Self-checking bench for des_key_sched_rev: known-answer runs, random keys with
// random backpressure, ignored mid-run starts, mid-run reset and back-to-back keys.
module tb_des_key_sched_rev;
  import des_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] KAT_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] KAT_K16 = 48'hCB3D8B0E17F5;

  des_key_sched_rev_if bus ();

  des_key_sched_rev #(.NUM_ROUNDS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Ki straight from the definition: C_i/D_i are C_0/D_0 left-rotated by the
  // cumulative shift, so C_i position p holds C_0 position (p + total) mod 28.
  function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int n);
    int       total = 0;
    bit       cd [57];
    logic [47:0] r;
    for (int i = 0; i < n; i++) total += SHIFTS[i];
    for (int p = 0; p < 28; p++) begin
      cd[p + 1]  = k[64 - PC1[(p + total) % 28]];
      cd[p + 29] = k[64 - PC1[28 + (p + total) % 28]];
    end
    for (int i = 0; i < 48; i++) r[47 - i] = cd[PC2[i]];
    return r;
  endfunction

  // Called on a negedge; returns on the negedge where the first subkey is visible.
  task automatic do_start(input logic [63:0] k, input logic dec);
    bus.key     = k;
    bus.decrypt = dec;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // Consumes a schedule, checking each presented subkey against the model.
  // stop_after > 0 returns right after that handshake is driven (before its edge).
  task automatic consume(input logic [63:0] k, input logic dec, input bit rand_ready,
                         input bit poke_start, input int stop_after,
                         output logic [47:0] last_sk);
    int          hs = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [47:0] prev_sk = '0;
    logic [3:0]  prev_idx = '0;
    int          i;
    bit          rdy;
    last_sk = '0;
    while (hs < 16 && cyc < 400) begin
      i = dec ? 16 - hs : hs + 1;
      check("subkey_valid", 64'(bus.subkey_valid), 64'd1);
      check("key_ready_busy", 64'(bus.key_ready), 64'd0);
      if (stalled) begin
        check("hold_subkey", 64'(bus.subkey), 64'(prev_sk));
        check("hold_idx", 64'(bus.subkey_idx), 64'(prev_idx));
      end
      check($sformatf("subkey_K%0d", i), 64'(bus.subkey), 64'(ref_subkey(k, i)));
      check($sformatf("idx_K%0d", i), 64'(bus.subkey_idx), 64'(i - 1));
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_start) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.key     = {$urandom, $urandom};
        bus.decrypt = ~dec;
      end
      bus.subkey_ready = rdy;
      prev_sk  = bus.subkey;
      prev_idx = bus.subkey_idx;
      stalled  = !rdy;
      if (rdy) begin
        hs++;
        last_sk = bus.subkey;
      end
      if (stop_after > 0 && hs == stop_after) begin
        bus.start = 1'b0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.subkey_ready = 1'b1;
    check("handshake_count", 64'(hs), 64'd16);
    check("done_pulse", 64'(bus.done), 64'd1);
    check("key_ready_on_done", 64'(bus.key_ready), 64'd1);
    check("valid_low_on_done", 64'(bus.subkey_valid), 64'd0);
  endtask

  initial begin
    logic [47:0] last;
    logic [63:0] k;
    logic        d;

    bus.key = '0; bus.decrypt = 1'b0; bus.start = 1'b0; bus.subkey_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_key_ready", 64'(bus.key_ready), 64'd1);
    check("rst_valid", 64'(bus.subkey_valid), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_subkey", 64'(bus.subkey), 64'd0);
    check("rst_idx", 64'(bus.subkey_idx), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer encrypt, full throughput.
    do_start(KAT_KEY, 1'b0);
    check("kat_enc_first", 64'(bus.subkey), 64'(KAT_K1));
    consume(KAT_KEY, 1'b0, 1'b0, 1'b0, 0, last);
    check("kat_enc_last", 64'(last), 64'(KAT_K16));
    check("done_one_cycle", 64'(bus.done), 64'd1);
    @(negedge clk);
    check("done_cleared", 64'(bus.done), 64'd0);

    // Known-answer decrypt.
    do_start(KAT_KEY, 1'b1);
    check("kat_dec_first", 64'(bus.subkey), 64'(KAT_K16));
    check("kat_dec_first_idx", 64'(bus.subkey_idx), 64'd15);
    consume(KAT_KEY, 1'b1, 1'b0, 1'b0, 0, last);
    check("kat_dec_last", 64'(last), 64'(KAT_K1));
    @(negedge clk);

    // Random keys and directions with random backpressure.
    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom};
      d = 1'($urandom_range(0, 1));
      do_start(k, d);
      consume(k, d, 1'b1, 1'b0, 0, last);
      @(negedge clk);
    end

    // Start pulses with other keys mid-run must be ignored.
    for (int n = 0; n < 2; n++) begin
      k = {$urandom, $urandom};
      d = 1'(n);
      do_start(k, d);
      consume(k, d, 1'b1, 1'b1, 0, last);
      @(negedge clk);
    end

    // Asynchronous reset right after the 5th handshake.
    k = {$urandom, $urandom};
    do_start(k, 1'b0);
    consume(k, 1'b0, 1'b1, 1'b0, 5, last);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_key_ready", 64'(bus.key_ready), 64'd1);
    check("midrst_valid", 64'(bus.subkey_valid), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_subkey", 64'(bus.subkey), 64'd0);
    check("midrst_idx", 64'(bus.subkey_idx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.subkey_ready = 1'b1;
    @(negedge clk);
    check("post_rst_idle_valid", 64'(bus.subkey_valid), 64'd0);
    do_start(KAT_KEY, 1'b0);
    check("post_rst_k1", 64'(bus.subkey), 64'(KAT_K1));
    consume(KAT_KEY, 1'b0, 1'b0, 1'b0, 0, last);

    // Back-to-back: new start on the done cycle with the all-zero key.
    do_start(64'h0, 1'b0);
    check("b2b_first", 64'(bus.subkey), 64'd0);
    consume(64'h0, 1'b0, 1'b1, 1'b0, 0, last);
    check("b2b_last", 64'(last), 64'd0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
